minmax_tracker: RTL and testbench

MINMAX_TRACKER -- requirements
Module: minmax_tracker

---
 rtl/minmax_pkg.sv | 13 +
 rtl/compare4.sv | 12 +
 rtl/minmax_tracker.sv | 140 ++++++++++++++
 tb/tb_minmax_tracker.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/minmax_pkg.sv
// Shared types and widths for the min/max frame tracker.
package minmax_pkg;

    localparam int DATA_W = 4;
    localparam int CNT_W  = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

endpackage

// File: rtl/compare4.sv
// Unsigned 4-bit magnitude comparator: more = a > b, less = a < b.
module compare4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic       more,
    output logic       less
);

    assign more = (a > b);
    assign less = (a < b);

endmodule

// File: rtl/minmax_tracker.sv
// Tracks min/max of each FRAME_LEN-sample frame and holds the result until consumed.
// Optional MINMAX_INDEX_EN adds first-occurrence positions of min and max.
module minmax_tracker
    import minmax_pkg::*;
#(
    parameter int FRAME_LEN = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] min_o,
    output logic [DATA_W-1:0] max_o
`ifdef MINMAX_INDEX_EN
    ,
    output logic [3:0]        min_idx_o,
    output logic [3:0]        max_idx_o
`endif
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_LEN - 1);

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  count;
    logic [DATA_W-1:0] acc_min, acc_max;
    logic [DATA_W-1:0] nxt_min, nxt_max;
    logic              gt_max, lt_min;
    logic              cmp_max_less_unused, cmp_min_more_unused;
    logic              accept, last, first;

    compare4 u_cmp_max (
        .a    (in_data),
        .b    (acc_max),
        .more (gt_max),
        .less (cmp_max_less_unused)
    );

    compare4 u_cmp_min (
        .a    (in_data),
        .b    (acc_min),
        .more (cmp_min_more_unused),
        .less (lt_min)
    );

    // flush beats a simultaneous sample; HOLD never accepts
    assign accept = in_valid & in_ready & ~flush & (state != HOLD);
    assign last   = accept & (count == LAST_CNT);
    assign first  = (state == IDLE);

    always_comb begin
        nxt_min = acc_min;
        nxt_max = acc_max;
        if (first || lt_min) nxt_min = in_data;
        if (first || gt_max) nxt_max = in_data;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) state_nxt = last ? HOLD : ACCUM;
            end
            ACCUM: begin
                if (flush)     state_nxt = IDLE;
                else if (last) state_nxt = HOLD;
            end
            HOLD: begin
                if (out_valid && out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // working accumulators are only meaningful once a frame has started
    always_ff @(posedge clk) begin
        if (accept) begin
            acc_min <= nxt_min;
            acc_max <= nxt_max;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count     <= '0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            min_o     <= '0;
            max_o     <= '0;
        end else begin
            if (flush && state != HOLD) count <= '0;
            else if (last)              count <= '0;
            else if (accept)            count <= count + 1'b1;
            in_ready  <= (state_nxt != HOLD);
            out_valid <= (state_nxt == HOLD);
            if (last) begin
                min_o <= nxt_min;
                max_o <= nxt_max;
            end
        end
    end

`ifdef MINMAX_INDEX_EN
    logic [3:0] acc_min_idx, acc_max_idx;
    logic [3:0] nxt_min_idx, nxt_max_idx;

    always_comb begin
        nxt_min_idx = acc_min_idx;
        nxt_max_idx = acc_max_idx;
        if (first || lt_min) nxt_min_idx = count[3:0];
        if (first || gt_max) nxt_max_idx = count[3:0];
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            acc_min_idx <= nxt_min_idx;
            acc_max_idx <= nxt_max_idx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            min_idx_o <= '0;
            max_idx_o <= '0;
        end else if (last) begin
            min_idx_o <= nxt_min_idx;
            max_idx_o <= nxt_max_idx;
        end
    end
`endif

endmodule

// File: tb/tb_minmax_tracker.sv
// Scoreboard bench for minmax_tracker (FRAME_LEN=4): directed frames then random traffic.
module tb_minmax_tracker;

    localparam int FL = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       flush = 1'b0;
    logic       in_valid = 1'b0;
    logic [3:0] in_data = '0;
    logic       in_ready;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [3:0] min_o, max_o;
`ifdef MINMAX_INDEX_EN
    logic [3:0] min_idx_o, max_idx_o;
`endif

    minmax_tracker #(.FRAME_LEN(FL)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .min_o     (min_o),
        .max_o     (max_o)
`ifdef MINMAX_INDEX_EN
        ,
        .min_idx_o (min_idx_o),
        .max_idx_o (max_idx_o)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int mn;
        int mx;
        int mni;
        int mxi;
    } res_t;

    res_t sb_q[$];
    int   frame_q[$];
    bit   pend = 1'b0;
    bit   exp_ready = 1'b0;
    bit   last_acc = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic res_t frame_result();
        res_t r;
        r.mn = frame_q[0]; r.mx = frame_q[0]; r.mni = 0; r.mxi = 0;
        for (int i = 1; i < frame_q.size(); i++) begin
            if (frame_q[i] < r.mn) begin r.mn = frame_q[i]; r.mni = i; end
            if (frame_q[i] > r.mx) begin r.mx = frame_q[i]; r.mxi = i; end
        end
        return r;
    endfunction

    // Reference behaviour, evaluated once per rising edge with the inputs then applied
    task automatic model_update();
        last_acc = 1'b0;
        if (!rst_n) begin
            frame_q.delete();
            sb_q.delete();
            pend = 1'b0;
            exp_ready = 1'b0;
        end else begin
            if (pend) begin
                if (out_ready) pend = 1'b0;
            end else if (flush) begin
                frame_q.delete();
            end else if (in_valid && exp_ready) begin
                last_acc = 1'b1;
                frame_q.push_back(int'(in_data));
                if (frame_q.size() == FL) begin
                    sb_q.push_back(frame_result());
                    frame_q.delete();
                    pend = 1'b1;
                end
            end
            exp_ready = !pend;
        end
    endtask

    task automatic step(input bit v, input int d, input bit f, input bit r);
        in_valid  = v;
        in_data   = 4'(d);
        flush     = f;
        out_ready = r;
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic send(input int d, input bit r);
        int tries = 0;
        do begin
            step(1'b1, d, 1'b0, r);
            tries++;
        end while (!last_acc && tries < 20);
        if (!last_acc) chk("send_timeout", 0, 1);
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            chk("in_ready", int'(in_ready), int'(exp_ready));
            chk("out_valid", int'(out_valid), int'(pend));
            if (out_valid) begin
                if (sb_q.size() == 0) begin
                    chk("result_unexpected", 1, 0);
                end else begin
                    chk("min_o", int'(min_o), sb_q[0].mn);
                    chk("max_o", int'(max_o), sb_q[0].mx);
`ifdef MINMAX_INDEX_EN
                    chk("min_idx_o", int'(min_idx_o), sb_q[0].mni);
                    chk("max_idx_o", int'(max_idx_o), sb_q[0].mxi);
`endif
                    if (out_ready) void'(sb_q.pop_front());
                end
            end
        end
    end

    initial begin
        #12;
        chk("rst_in_ready", int'(in_ready), 0);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_min", int'(min_o), 0);
        chk("rst_max", int'(max_o), 0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // basic frame, equal samples, held result with blocked input
        send(5, 1); send(2, 1); send(9, 1); send(7, 1);
        step(1'b0, 0, 1'b0, 1'b1);
        step(1'b0, 0, 1'b0, 1'b1);
        send(3, 1); send(3, 1); send(3, 1); send(3, 1);
        step(1'b0, 0, 1'b0, 1'b1);
        send(0, 0); send(15, 0); send(15, 0); send(0, 0);
        for (int i = 0; i < 5; i++) step(1'b1, 9, 1'b0, 1'b0);
        step(1'b1, 9, 1'b0, 1'b1);

        // flush drops the partial frame and the concurrent sample
        send(8, 1); send(1, 1);
        step(1'b1, 0, 1'b1, 1'b1);
        send(4, 1); send(6, 1); send(5, 1); send(7, 1);
        step(1'b0, 0, 1'b0, 1'b1);
        step(1'b0, 0, 1'b0, 1'b1);

        // asynchronous reset mid-frame
        send(6, 1); send(11, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_in_ready", int'(in_ready), 0);
        chk("arst_out_valid", int'(out_valid), 0);
        chk("arst_min", int'(min_o), 0);
        chk("arst_max", int'(max_o), 0);
        step(1'b0, 0, 1'b0, 1'b1);
        step(1'b0, 0, 1'b0, 1'b1);
        rst_n = 1'b1;
        send(1, 1); send(2, 1); send(3, 1); send(4, 1);
        step(1'b0, 0, 1'b0, 1'b1);

        for (int i = 0; i < 500; i++)
            step(($urandom % 4) != 0, int'($urandom_range(0, 15)),
                 ($urandom % 12) == 0, ($urandom % 3) != 0);

        for (int i = 0; i < 4; i++) step(1'b0, 0, 1'b0, 1'b1);
        chk("scoreboard_drained", sb_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
